// File: rtl/y86_dmem_ctrl.sv
// Y86-64 memory-stage data-memory controller with a LATENCY-cycle RAM and a done/valM/dmem_error response.
// Optional feature macro: ALIGN_CHECK_EN makes any read or write with addr[2:0] != 0 fault.
module y86_dmem_ctrl #(
  parameter int    DATA_W    = 64,
  parameter int    DEPTH     = 128,
  parameter int    ADDR_W    = 64,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "DATA_MEM.txt"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output logic              done,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 8);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_rd, op_wr, op_fault;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  ram [DEPTH];

  logic               dec_rd, dec_wr, dec_fault;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wdata;
  logic               accept;
  logic               ram_we;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_rd    = 1'b0;
    dec_wr    = 1'b0;
    addr      = valE[ADDR_W-1:0];
    wdata     = valA;
    if (instr_valid) begin
      case (icode)
        4'h4: dec_wr = 1'b1;
        4'h5: dec_rd = 1'b1;
        4'h8: begin dec_wr = 1'b1; wdata = valP; end
        4'h9: begin dec_rd = 1'b1; addr = valA[ADDR_W-1:0]; end
        4'hA: dec_wr = 1'b1;
        4'hB: begin dec_rd = 1'b1; addr = valA[ADDR_W-1:0]; end
        default: ;
      endcase
    end
    dec_fault = (dec_rd | dec_wr) && (addr >= LIMIT);
`ifdef ALIGN_CHECK_EN
    if ((dec_rd | dec_wr) && (addr[2:0] != 3'b000)) dec_fault = 1'b1;
`else
`endif
  end

  assign accept = req_valid & req_ready;
  assign ram_we = (state == BUSY) && (cnt == '0) && op_wr && !op_fault;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      done       <= 1'b0;
      valM       <= '0;
      dmem_error <= 1'b0;
      op_rd      <= 1'b0;
      op_wr      <= 1'b0;
      op_fault   <= 1'b0;
      idx        <= '0;
      wdata_q    <= '0;
    end else begin
      done       <= 1'b0;
      dmem_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            cnt       <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            op_rd     <= dec_rd;
            op_wr     <= dec_wr;
            op_fault  <= dec_fault;
            idx       <= addr[IDX_W+2:3];
            wdata_q   <= wdata;
          end else begin
            req_ready <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state      <= RESP;
            done       <= 1'b1;
            dmem_error <= op_fault;
            valM       <= (op_rd && !op_fault) ? ram[idx] : '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst_n, and an aborted access never writes.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= wdata_q;
  end

endmodule
